parking_gate_arbiter: RTL and testbench

Controller that shares the single-lane barrier gate of the car park between the entrance and exit requesters. It arbitrates simultaneous requests round-robin, sequences password check, gate open and car clearance, and maintains the occupancy count against a fixed capacity. Its status outputs feed the LED and seven-segment display logic of the parking system.

---
 rtl/parking_gate_arbiter.sv | 114 +++++++++++
 tb/tb_parking_gate_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: round-robin entrance/exit arbiter for the car park's single barrier gate
module parking_gate_arbiter #(
    parameter int         CAPACITY     = 8,
    parameter int         CNT_W        = 4,
    parameter logic [1:0] PASS_1       = 2'b01,
    parameter logic [1:0] PASS_2       = 2'b10,
    parameter int         PASS_TIMEOUT = 16,
    parameter int         GATE_TIMEOUT = 32,
    parameter int         MAX_TRIES    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic [1:0]       password_1,
    input  logic [1:0]       password_2,
    input  logic             pass_valid,
    input  logic             car_passed,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             gate_open,
    output logic             wrong_pass,
    output logic             lot_full,
    output logic [CNT_W-1:0] occupancy,
    output logic             busy
);
    localparam int TMAX  = (PASS_TIMEOUT > GATE_TIMEOUT) ? PASS_TIMEOUT : GATE_TIMEOUT;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_PASS, ENTRY_OPEN, EXIT_OPEN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic               last_entry_q, last_entry_d;
    logic               wrong_q, wrong_d;
    logic               full, entry_ok, exit_ok, pass_match;

    assign full       = occ_q == CNT_W'(CAPACITY);
    assign entry_ok   = entry_req && !full;
    assign exit_ok    = exit_req && occ_q != '0;
    assign pass_match = password_1 == PASS_1 && password_2 == PASS_2;

    // State and bookkeeping registers; reset clears everything including occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            occ_q        <= '0;
            timer_q      <= '0;
            tries_q      <= '0;
            last_entry_q <= 1'b0;
            wrong_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            timer_q      <= timer_d;
            tries_q      <= tries_d;
            last_entry_q <= last_entry_d;
            wrong_q      <= wrong_d;
        end
    end

    // Arbitration, password sequencing and gate timeouts; timer restarts on every state entry
    always_comb begin
        state_d      = state_q;
        occ_d        = occ_q;
        timer_d      = timer_q + TMR_W'(1);
        tries_d      = tries_q;
        last_entry_d = last_entry_q;
        wrong_d      = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (entry_ok && (!exit_ok || !last_entry_q))
                    state_d = WAIT_PASS;
                else if (exit_ok)
                    state_d = EXIT_OPEN;
            end
            WAIT_PASS: begin
                if (pass_valid && pass_match) begin
                    state_d = ENTRY_OPEN;
                    timer_d = '0;
                    tries_d = '0;
                end else if (pass_valid) begin
                    wrong_d = 1'b1;
                    tries_d = (tries_q == TRY_W'(MAX_TRIES - 1)) ? '0 : tries_q + TRY_W'(1);
                    state_d = (tries_q == TRY_W'(MAX_TRIES - 1)) ? IDLE : WAIT_PASS;
                end else if (timer_q >= TMR_W'(PASS_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    tries_d = '0;
                end
            end
            default: begin
                if (car_passed) begin
                    state_d      = IDLE;
                    last_entry_d = state_q == ENTRY_OPEN;
                    occ_d        = (state_q == ENTRY_OPEN) ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);
                end else if (timer_q >= TMR_W'(GATE_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign entry_grant = state_q == WAIT_PASS || state_q == ENTRY_OPEN;
    assign exit_grant  = state_q == EXIT_OPEN;
    assign gate_open   = state_q == ENTRY_OPEN || state_q == EXIT_OPEN;
    assign wrong_pass  = wrong_q;
    assign lot_full    = full;
    assign occupancy   = occ_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_parking_gate_arbiter;
    localparam int CAP = 8;
    localparam int PT  = 16;
    localparam int GT  = 32;
    localparam int MT  = 3;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       entry_req = 1'b0, exit_req = 1'b0, pass_valid = 1'b0, car_passed = 1'b0;
    logic [1:0] password_1 = 2'b00, password_2 = 2'b00;
    logic       entry_grant, exit_grant, gate_open, wrong_pass, lot_full, busy;
    logic [3:0] occupancy;
    logic [9:0] dut_out;

    int n_checks = 0;
    int n_fail   = 0;

    // model: phase 0 idle, 1 awaiting password, 2 entrance gate up, 3 exit gate up
    int m_phase, m_elapsed, m_cars, m_misses;
    bit m_entry_last, m_wrong;

    always #5 clk = ~clk;

    parking_gate_arbiter #(
        .CAPACITY(CAP), .CNT_W(4), .PASS_1(2'b01), .PASS_2(2'b10),
        .PASS_TIMEOUT(PT), .GATE_TIMEOUT(GT), .MAX_TRIES(MT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .exit_req(exit_req),
        .password_1(password_1), .password_2(password_2), .pass_valid(pass_valid),
        .car_passed(car_passed), .entry_grant(entry_grant), .exit_grant(exit_grant),
        .gate_open(gate_open), .wrong_pass(wrong_pass), .lot_full(lot_full),
        .occupancy(occupancy), .busy(busy)
    );

    assign dut_out = {entry_grant, exit_grant, gate_open, wrong_pass, lot_full, busy, occupancy};

    function automatic logic [9:0] model_out();
        return {m_phase == 1 || m_phase == 2, m_phase == 3, m_phase >= 2, m_wrong,
                m_cars == CAP, m_phase != 0, 4'(m_cars)};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_elapsed = 0; m_cars = 0; m_misses = 0; m_entry_last = 0; m_wrong = 0;
    endtask

    task automatic model_edge();
        bit want_in, want_out;
        m_wrong = 0;
        if (m_phase == 0) begin
            want_in   = entry_req && m_cars < CAP;
            want_out  = exit_req && m_cars > 0;
            m_elapsed = 0;
            if (want_in && want_out) m_phase = m_entry_last ? 3 : 1;
            else if (want_in)        m_phase = 1;
            else if (want_out)       m_phase = 3;
        end else if (m_phase == 1) begin
            if (pass_valid && password_1 == 2'b01 && password_2 == 2'b10) begin
                m_phase = 2; m_elapsed = 0; m_misses = 0;
            end else if (pass_valid) begin
                m_wrong = 1; m_misses++; m_elapsed++;
                if (m_misses == MT) begin m_phase = 0; m_misses = 0; end
            end else if (m_elapsed + 1 >= PT) begin
                m_phase = 0; m_misses = 0;
            end else m_elapsed++;
        end else begin
            if (car_passed) begin
                m_cars += (m_phase == 2) ? 1 : -1;
                m_entry_last = (m_phase == 2);
                m_phase = 0;
            end else if (m_elapsed + 1 >= GT) m_phase = 0;
            else m_elapsed++;
        end
    endtask

    task automatic step(input logic en, input logic ex, input logic pv,
                        input logic [1:0] p1, input logic [1:0] p2, input logic cp);
        entry_req = en; exit_req = ex; pass_valid = pv;
        password_1 = p1; password_2 = p2; car_passed = cp;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 2'b00, 0);
    endtask

    task automatic do_entry();
        step(1, 0, 0, 2'b00, 2'b00, 0);
        step(0, 0, 1, 2'b01, 2'b10, 0);
        step(0, 0, 0, 2'b00, 2'b00, 1);
    endtask

    task automatic do_exit();
        step(0, 1, 0, 2'b00, 2'b00, 0);
        step(0, 0, 0, 2'b00, 2'b00, 1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(0, 0, 0, 2'b00, 2'b00, 0);
        model_reset();
        #1 reset_n = 1'b1;
        n_checks++;
        if (dut_out !== 10'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", dut_out, 10'd0);
        end
        idle(2);
        n_checks++;
        if (dut_out !== 10'd0) begin
            n_fail++; $display("FAIL reset_idle: got %b expected %b", dut_out, 10'd0);
        end
    endtask

    task automatic test_basic_entry();
        step(1, 0, 0, 2'b00, 2'b00, 0);
        n_checks++;
        if ({entry_grant, gate_open, busy} !== 3'b101) begin
            n_fail++; $display("FAIL entry_grant_latency: got %b expected 101", {entry_grant, gate_open, busy});
        end
        step(0, 0, 1, 2'b01, 2'b10, 0);
        n_checks++;
        if ({entry_grant, gate_open, wrong_pass} !== 3'b110) begin
            n_fail++; $display("FAIL entry_gate_open: got %b expected 110", {entry_grant, gate_open, wrong_pass});
        end
        step(0, 0, 0, 2'b00, 2'b00, 1);
        n_checks++;
        if ({busy, gate_open, occupancy} !== {2'b00, 4'd1}) begin
            n_fail++; $display("FAIL entry_car_passed: got %b expected 00_0001", {busy, gate_open, occupancy});
        end
    endtask

    task automatic test_round_robin();
        do_entry();
        do_exit();
        step(1, 1, 0, 2'b00, 2'b00, 0);
        n_checks++;
        if ({entry_grant, exit_grant} !== 2'b10) begin
            n_fail++; $display("FAIL rr_first_tie: got %b expected 10", {entry_grant, exit_grant});
        end
        step(0, 0, 1, 2'b01, 2'b10, 0);
        step(0, 0, 0, 2'b00, 2'b00, 1);
        step(1, 1, 0, 2'b00, 2'b00, 0);
        n_checks++;
        if ({entry_grant, exit_grant, gate_open} !== 3'b011) begin
            n_fail++; $display("FAIL rr_second_tie: got %b expected 011", {entry_grant, exit_grant, gate_open});
        end
        step(0, 0, 0, 2'b00, 2'b00, 1);
        n_checks++;
        if (occupancy !== 4'd1) begin
            n_fail++; $display("FAIL rr_occupancy: got %0d expected 1", occupancy);
        end
    endtask

    task automatic test_wrong_pass();
        bit opened;
        opened = 0;
        step(1, 0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < MT; i++) begin
            step(0, 0, 1, 2'b11, 2'b11, 0);
            opened |= gate_open;
            n_checks++;
            if ({wrong_pass, busy} !== {1'b1, i != MT - 1}) begin
                n_fail++; $display("FAIL wrong_pass_%0d: got %b expected %b", i, {wrong_pass, busy}, {1'b1, i != MT - 1});
            end
        end
        idle(1);
        n_checks++;
        if ({opened, wrong_pass, busy, occupancy} !== {3'b000, 4'd1}) begin
            n_fail++; $display("FAIL wrong_pass_end: got %b expected 000_0001", {opened, wrong_pass, busy, occupancy});
        end
    endtask

    task automatic test_capacity();
        for (int i = 1; i < CAP; i++) do_entry();
        n_checks++;
        if ({lot_full, occupancy} !== {1'b1, 4'd8}) begin
            n_fail++; $display("FAIL full_reached: got %b expected 1_1000", {lot_full, occupancy});
        end
        step(1, 0, 0, 2'b00, 2'b00, 0);
        step(1, 0, 1, 2'b01, 2'b10, 0);
        n_checks++;
        if ({entry_grant, busy, lot_full} !== 3'b001) begin
            n_fail++; $display("FAIL full_refused: got %b expected 001", {entry_grant, busy, lot_full});
        end
        do_exit();
        n_checks++;
        if ({lot_full, occupancy} !== {1'b0, 4'd7}) begin
            n_fail++; $display("FAIL full_exit: got %b expected 0_0111", {lot_full, occupancy});
        end
    endtask

    task automatic test_timeouts();
        step(0, 1, 0, 2'b00, 2'b00, 0);
        idle(GT - 1);
        n_checks++;
        if (gate_open !== 1'b1) begin
            n_fail++; $display("FAIL gate_before_timeout: got %b expected 1", gate_open);
        end
        idle(1);
        n_checks++;
        if ({gate_open, busy, occupancy} !== {2'b00, 4'd7}) begin
            n_fail++; $display("FAIL gate_timeout: got %b expected 00_0111", {gate_open, busy, occupancy});
        end
        step(1, 0, 0, 2'b00, 2'b00, 0);
        idle(PT - 1);
        n_checks++;
        if (entry_grant !== 1'b1) begin
            n_fail++; $display("FAIL pass_before_timeout: got %b expected 1", entry_grant);
        end
        idle(1);
        n_checks++;
        if ({entry_grant, busy} !== 2'b00) begin
            n_fail++; $display("FAIL pass_timeout: got %b expected 00", {entry_grant, busy});
        end
        step(1, 0, 0, 2'b00, 2'b00, 0);
        idle(PT - 1);
        step(0, 0, 1, 2'b01, 2'b10, 0);
        n_checks++;
        if (gate_open !== 1'b1) begin
            n_fail++; $display("FAIL pass_at_expiry: got %b expected 1", gate_open);
        end
        idle(GT - 1);
        step(0, 0, 0, 2'b00, 2'b00, 1);
        n_checks++;
        if ({busy, occupancy} !== {1'b0, 4'd8}) begin
            n_fail++; $display("FAIL car_at_expiry: got %b expected 0_1000", {busy, occupancy});
        end
    endtask

    task automatic test_async_reset();
        do_exit();
        do_exit();
        do_exit();
        step(1, 0, 0, 2'b00, 2'b00, 0);
        step(0, 0, 1, 2'b01, 2'b10, 0);
        n_checks++;
        if ({gate_open, occupancy} !== {1'b1, 4'd5}) begin
            n_fail++; $display("FAIL pre_reset_state: got %b expected 1_0101", {gate_open, occupancy});
        end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dut_out !== 10'd0) begin
            n_fail++; $display("FAIL async_reset: got %b expected %b", dut_out, 10'd0);
        end
        step(1, 1, 0, 2'b00, 2'b00, 0);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic en, ex, pv, cp;
        logic [1:0] p1, p2;
        for (int i = 0; i < 3000; i++) begin
            en = $urandom_range(0, 9) < 6;
            ex = $urandom_range(0, 9) < 4;
            pv = $urandom_range(0, 9) < 3;
            cp = $urandom_range(0, 9) < 2;
            p1 = ($urandom_range(0, 9) < 7) ? 2'b01 : 2'($urandom);
            p2 = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom);
            step(en, ex, pv, p1, p2, cp);
            n_checks++;
            if (dut_out !== model_out()) begin
                n_fail++; $display("FAIL random_cycle_%0d: got %b expected %b", i, dut_out, model_out());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_entry();
        test_round_robin();
        test_wrong_pass();
        test_capacity();
        test_timeouts();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
